avr_serial_tx: RTL and testbench
================================

Name: avr_serial_tx

Overview:
- UART-style transmitter that drives the FPGA-to-AVR serial line (board net avr_rx) on the Mojo.
- Buffers bytes from fabric logic in a small FIFO and serialises them 8N1, LSB first.
- Honours the AVR's Rx-buffer-full flag (avr_rx_busy) between frames.
- Instantiated in mojo_top with tx wired to avr_rx and block wired to avr_rx_busy.

Parameters:
- CLK_PER_BIT, 100, clk cycles per serial bit (50 MHz / 500 kbaud); integer >= 2.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  synchronous reset, active-high.
- tx_data  input  8  byte to send.
- tx_valid  input  1  push strobe; tx_data is written when tx_valid=1 and the push is accepted.
- tx_full  output  1  FIFO holds FIFO_DEPTH bytes.
- tx_overflow  output  1  one-cycle pulse when a push is dropped.
- block  input  1  AVR Rx buffer full, asynchronous to clk.
- busy  output  1  FIFO non-empty, or a frame is in progress.
- tx  output  1  serial line; idle high.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state changes on the rising clk edge.
- Reset values: tx=1, busy=0, tx_full=0, tx_overflow=0; FIFO empty; FSM=IDLE; counters=0; synchroniser flops=1.
- Reset mid-frame: the frame is abandoned, tx=1 on the cycle after rst is sampled, and all queued bytes are discarded.
- block handling: passes through a 2-flop synchroniser (block_s). It is sampled only in IDLE and never aborts or stretches a frame in progress.

FIFO:
- A push is accepted when tx_valid=1 and (count<FIFO_DEPTH, or a pop occurs in the same cycle).
- Otherwise the byte is dropped and tx_overflow=1 for exactly that cycle; FIFO contents are unchanged.
- tx_full = (count==FIFO_DEPTH), registered from count.
- Pointers wrap modulo FIFO_DEPTH.

FSM states and transitions:
- IDLE: tx=1. If FIFO non-empty and block_s=0: pop head into shift register, go to START.
- START: tx=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift[0] for CLK_PER_BIT cycles per bit; shift right after each bit. After bit 7 go to PARITY if enabled, else STOP.
- STOP: tx=1 for CLK_PER_BIT cycles.
  - At the end, if FIFO non-empty and block_s=0: pop and go directly to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.

Timing:
- Bit timer counts 0..CLK_PER_BIT-1 and restarts at each bit boundary.
- Frame length is exactly 10*CLK_PER_BIT cycles (11 with parity).
- Latency: with FIFO empty, FSM in IDLE and block_s=0, tx first goes low 2 cycles after the cycle in which tx_valid is sampled (1 cycle FIFO write, 1 cycle IDLE pop).
- busy rises on the cycle after an accepted push. It falls on the cycle the FSM enters IDLE with the FIFO empty.
- block asserted mid-frame: the current frame completes; the next byte waits in IDLE until block_s=0.

Optional Feature:
- Macro: AVR_SERIAL_TX_PARITY_EN.
- Defined: a PARITY state after DATA transmits the even-parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles; frame = 11*CLK_PER_BIT cycles (8E1).
- Undefined: no PARITY state and no parity logic; frame = 10*CLK_PER_BIT cycles (8N1).

Test Plan:
- Single byte (CLK_PER_BIT=4): push 0xA5 from idle → tx low 2 cycles after push; line pattern 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; busy=0 one cycle after the stop bit ends.
- Back-to-back: push 0x00 then 0xFF in consecutive cycles → two contiguous 40-cycle frames, stop bit of frame 1 immediately followed by start bit of frame 2; tx_full never asserts.
- Overflow (FIFO_DEPTH=4, block=1): push 0x01..0x05 → tx_full=1 after the 4th push; 5th push gives a one-cycle tx_overflow pulse; tx stays 1. Release block → 0x01..0x04 sent in order; 0x05 never appears.
- Block mid-frame: assert block during bit 3 of 0x3C with 0x7E queued → 0x3C completes; tx held 1 until block deasserts, then 0x7E starts within 3 cycles.
- Reset mid-frame: assert rst during the DATA state with 2 bytes queued → tx=1, busy=0, tx_full=0 the next cycle; no further frames after rst deasserts.
- Parity (macro defined): push 0x07 → parity bit 1; push 0x03 → parity bit 0; frame length 44 cycles at CLK_PER_BIT=4.

Source files
------------

// File: rtl/avr_serial_tx.sv
// FIFO-buffered 8N1 serial transmitter for the FPGA-to-AVR link, LSB first, honouring avr_rx_busy.
// Define AVR_SERIAL_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module avr_serial_tx #(
  parameter int unsigned CLK_PER_BIT = 100,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_full,
  output logic       tx_overflow,
  input  logic       block,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TimW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [TimW-1:0] TimLast = TimW'(CLK_PER_BIT - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

`ifdef AVR_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [TimW-1:0] timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            block_meta_q, block_s_q;
`ifdef AVR_SERIAL_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop, fifo_nonempty, bit_end;

  assign fifo_nonempty = (count_q != '0);
  assign bit_end       = (timer_q == TimLast);
  // A full FIFO still accepts a push when the FSM pops in the same cycle.
  assign push          = tx_valid && ((count_q != CntFull) || pop);
  assign tx_overflow   = tx_valid && !push && !rst;
  assign tx_full       = (count_q == CntFull);
  assign busy          = fifo_nonempty || (state_q != StIdle);
  assign tx            = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      block_meta_q <= 1'b1;
      block_s_q    <= 1'b1;
    end else begin
      block_meta_q <= block;
      block_s_q    <= block_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef AVR_SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    timer_d = (state_q == StIdle || bit_end) ? '0 : timer_q + TimW'(1);
    case (state_q)
      StIdle: begin
        if (fifo_nonempty && !block_s_q) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = 3'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef AVR_SERIAL_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef AVR_SERIAL_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (fifo_nonempty && !block_s_q) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      shift_d = mem[rd_ptr_q];
`ifdef AVR_SERIAL_TX_PARITY_EN
      parity_d = ^mem[rd_ptr_q];
`endif
    end
  end

  // The line level is registered from the next state so tx is glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef AVR_SERIAL_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef AVR_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef AVR_SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_avr_serial_tx.sv
// Scoreboard bench for avr_serial_tx: accepted bytes are queued, a line monitor decodes every
// frame cycle by cycle and compares it with the queued byte.
module tb_avr_serial_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef AVR_SERIAL_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NBITS = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       block = 1'b0;
  logic       tx_full, tx_overflow, busy, tx;

  avr_serial_tx #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_full     (tx_full),
    .tx_overflow (tx_overflow),
    .block       (block),
    .busy        (busy),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int chks = 0;

  logic [7:0] sb[$];
  int  frames_started = 0;
  int  frames_done    = 0;
  int  last_gap       = 0;
  bit  in_frame       = 1'b0;
  bit  full_seen      = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    chks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    chks++;
    errs++;
    $display("FAIL %s: got=timeout expected=event at %0t", name, $time);
  endtask

  // Each stimulus task ends on a falling edge, where outputs are sampled.
  task automatic push(input logic [7:0] d, input bit exp_acc);
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    check("overflow_on_push", int'(tx_overflow), int'(!exp_acc));
    if (exp_acc) sb.push_back(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_frames(input int target, input string name);
    int k;
    k = 0;
    while (frames_done < target && k < 20 * FRAME_CYC) begin
      idle(1);
      k++;
    end
    if (frames_done < target) timeout_fail(name);
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    while (!in_frame && k < 50) begin
      idle(1);
      k++;
    end
    if (!in_frame) timeout_fail(name);
  endtask

  // Line monitor: reference frame = start 0, data LSB first, optional even parity, stop 1.
  initial begin
    int         cyc, bitn, gap, lvl;
    bit         shape_ok, unexp;
    logic [7:0] exp_b, got;
    cyc = 0; gap = 0; shape_ok = 1'b1; unexp = 1'b0; exp_b = '0; got = '0;
    forever begin
      @(negedge clk);
      if (tx_full) full_seen = 1'b1;
      if (rst) begin
        in_frame = 1'b0;
        gap = 0;
      end else begin
        if (!in_frame && tx == 1'b0) begin
          in_frame = 1'b1;
          cyc = 0;
          shape_ok = 1'b1;
          got = '0;
          last_gap = gap;
          gap = 0;
          frames_started++;
          if (sb.size() == 0) begin
            unexp = 1'b1;
            exp_b = '0;
          end else begin
            unexp = 1'b0;
            exp_b = sb.pop_front();
          end
        end else if (!in_frame) begin
          gap++;
        end
        if (in_frame) begin
          bitn = cyc / CPB;
          if (bitn == 0)                 lvl = 0;
          else if (bitn <= 8)            lvl = int'(exp_b[bitn-1]);
          else if (PAR && bitn == 9)     lvl = $countones(exp_b) % 2;
          else                           lvl = 1;
          if (tx !== lvl[0]) shape_ok = 1'b0;
          if (bitn >= 1 && bitn <= 8 && (cyc % CPB) == CPB / 2) got[bitn-1] = tx;
          cyc++;
          if (cyc == FRAME_CYC) begin
            in_frame = 1'b0;
            frames_done++;
            chks++;
            if (unexp || !shape_ok || got != exp_b) begin
              errs++;
              if (unexp)
                $display("FAIL frame: got=%02h expected=none (unexpected frame) at %0t",
                         got, $time);
              else
                $display("FAIL frame: got=%02h shape_ok=%0d expected=%02h shape_ok=1 at %0t",
                         got, shape_ok, exp_b, $time);
            end
          end
        end
      end
    end
  end

  initial begin
    int base, fs, k;
    bit seen_low, quiet;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_full", int'(tx_full), 0);
    check("reset_overflow", int'(tx_overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);

    // Single byte: latency, bit pattern (monitor), busy release
    push(8'hA5, 1'b1);
    idle(1);
    check("latency_tx_high_c1", int'(tx), 1);
    check("busy_after_push", int'(busy), 1);
    idle(1);
    check("latency_tx_low_c2", int'(tx), 0);
    idle(FRAME_CYC - 1);
    check("busy_last_stop_cycle", int'(busy), 1);
    idle(1);
    check("busy_after_frame", int'(busy), 0);
    check("tx_idle_after_frame", int'(tx), 1);
    idle(3);

    // Back-to-back frames
    full_seen = 1'b0;
    base = frames_done;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    idle(1);
    wait_frames(base + 2, "b2b_frames");
    check("b2b_gap", last_gap, 0);
    check("b2b_full_never", int'(full_seen), 0);
    idle(5);

    // Overflow with the AVR blocking
    block = 1'b1;
    idle(3);
    fs = frames_started;
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b1);
    push(8'h05, 1'b0);
    check("full_after_4", int'(tx_full), 1);
    idle(1);
    check("overflow_one_cycle", int'(tx_overflow), 0);
    idle(10);
    check("blocked_tx_high", int'(tx), 1);
    check("blocked_no_frame", frames_started - fs, 0);
    block = 1'b0;
    wait_frames(frames_done + 4, "overflow_drain");
    idle(2 * FRAME_CYC);
    check("overflow_frames", frames_started - fs, 4);

    // Block asserted mid-frame
    base = frames_done;
    push(8'h3C, 1'b1);
    push(8'h7E, 1'b1);
    idle(1);
    wait_start("block_first_start");
    idle(4 * CPB + 1);
    block = 1'b1;
    wait_frames(base + 1, "block_first_done");
    fs = frames_started;
    quiet = 1'b1;
    for (int i = 0; i < FRAME_CYC; i++) begin
      idle(1);
      if (tx !== 1'b1) quiet = 1'b0;
    end
    check("block_holds_line", int'(quiet), 1);
    check("block_no_start", frames_started - fs, 0);
    block = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 3 && !seen_low; i++) begin
      idle(1);
      if (tx == 1'b0) seen_low = 1'b1;
    end
    check("unblock_start_within_3", int'(seen_low), 1);
    wait_frames(base + 2, "block_second_done");
    idle(3);

    // Reset mid-frame with bytes queued
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    idle(1);
    wait_start("reset_frame_start");
    idle(3 * CPB);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_tx", int'(tx), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_full", int'(tx_full), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fs = frames_started;
    idle(3 * FRAME_CYC);
    check("rst_no_frames", frames_started - fs, 0);
    check("rst_idle_busy", int'(busy), 0);

    // Parity bytes from the test plan (parity bit checked by the monitor when enabled)
    base = frames_done;
    push(8'h07, 1'b1);
    push(8'h03, 1'b1);
    idle(1);
    wait_frames(base + 2, "parity_frames");

    // Randomised traffic with random blocking
    base = frames_done;
    fs = 0;
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 5));
      block = ($urandom_range(0, 3) == 0);
      k = 0;
      while (sb.size() >= DEPTH && k < 20 * FRAME_CYC) begin
        block = 1'b0;
        idle(1);
        k++;
      end
      push(8'($urandom), 1'b1);
      fs++;
    end
    block = 1'b0;
    idle(1);
    wait_frames(base + fs, "random_drain");
    idle(FRAME_CYC);
    check("random_queue_empty", sb.size(), 0);
    check("random_busy_done", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
